// File: rtl/div_rasterizer_iter.sv
// rtl/div_rasterizer_iter.sv - radix-2 signed fixed-point divider with tagged result FIFO
// Define DIV_SATURATE_EN to clamp out-of-range quotients instead of wrapping them.
module div_rasterizer_iter #(
  parameter int DIVIDEND_WIDTH   = 64,
  parameter int DIVISOR_WIDTH    = 64,
  parameter int FRACTIONAL_WIDTH = 16,
  parameter int OUT_WIDTH        = DIVIDEND_WIDTH + FRACTIONAL_WIDTH + 1,
  parameter int TAG_WIDTH        = 4,
  parameter int OUT_DEPTH        = 4,
  localparam int TDATA_W         = 8 * ((OUT_WIDTH + 7) / 8)
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_dividend_tvalid,
  output logic                      s_axis_dividend_tready,
  input  logic [DIVIDEND_WIDTH-1:0] s_axis_dividend_tdata,
  input  logic [TAG_WIDTH-1:0]      s_axis_dividend_tuser,
  input  logic                      s_axis_divisor_tvalid,
  output logic                      s_axis_divisor_tready,
  input  logic [DIVISOR_WIDTH-1:0]  s_axis_divisor_tdata,
  output logic                      m_axis_dout_tvalid,
  input  logic                      m_axis_dout_tready,
  output logic [TDATA_W-1:0]        m_axis_dout_tdata,
  output logic [TAG_WIDTH+1:0]      m_axis_dout_tuser,
  output logic                      busy
);
  localparam int DW      = DIVIDEND_WIDTH;
  localparam int VW      = DIVISOR_WIDTH;
  localparam int NUM_W   = DW + FRACTIONAL_WIDTH;
  localparam int EXT_W   = (OUT_WIDTH > NUM_W + 1) ? OUT_WIDTH : NUM_W + 1;
  localparam int CNT_W   = $clog2(NUM_W + 1);
  localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCC_W   = $clog2(OUT_DEPTH + 1);
  localparam int ENTRY_W = TAG_WIDTH + 2 + OUT_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state;
  logic                 dvd_valid, dvs_valid;
  logic [DW-1:0]        dvd_data;
  logic [TAG_WIDTH-1:0] dvd_tag;
  logic [VW-1:0]        dvs_data;

  logic [NUM_W-1:0]     num;
  logic [NUM_W-1:0]     quo;
  logic [VW-1:0]        dvs_mag;
  logic [VW-1:0]        rem;
  logic                 neg, dbz;
  logic [TAG_WIDTH-1:0] tag;
  logic [CNT_W-1:0]     cnt;

  logic [ENTRY_W-1:0]   mem [OUT_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ;

  logic                 start, push, pop;
  logic [DW-1:0]        dvd_abs;
  logic [VW-1:0]        dvs_abs;
  logic [VW:0]          rem_sh, rem_sub;
  logic                 ge;
  logic [EXT_W-1:0]     q_pos, q_ext, q_back;
  logic [OUT_WIDTH-1:0] q_low, res;
  logic                 ovf;
  logic [ENTRY_W-1:0]   head;

  assign s_axis_dividend_tready = !dvd_valid;
  assign s_axis_divisor_tready  = !dvs_valid;

  assign start = (state == IDLE) && dvd_valid && dvs_valid && (occ < OCC_W'(OUT_DEPTH));
  assign push  = (state == FIN);
  assign pop   = m_axis_dout_tvalid && m_axis_dout_tready;

  assign dvd_abs = dvd_data[DW-1] ? (~dvd_data + 1'b1) : dvd_data;
  assign dvs_abs = dvs_data[VW-1] ? (~dvs_data + 1'b1) : dvs_data;

  // Remainder stays below dvs_mag, so one extra bit covers the shifted trial value.
  assign rem_sh  = {rem, num[NUM_W-1]};
  assign ge      = rem_sh >= {1'b0, dvs_mag};
  assign rem_sub = rem_sh - {1'b0, dvs_mag};

  assign q_pos  = EXT_W'(quo);
  assign q_ext  = neg ? (~q_pos + 1'b1) : q_pos;
  assign q_low  = q_ext[OUT_WIDTH-1:0];
  assign q_back = EXT_W'(signed'(q_low));
  assign ovf    = (q_back != q_ext);

`ifdef DIV_SATURATE_EN
  logic [OUT_WIDTH-1:0] sat;
  assign sat = q_ext[EXT_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  assign res = ovf ? sat : q_low;
`else
  assign res = q_low;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      dvd_valid <= 1'b0;
      dvs_valid <= 1'b0;
      dvd_data  <= '0;
      dvd_tag   <= '0;
      dvs_data  <= '0;
    end else begin
      if (s_axis_dividend_tvalid && !dvd_valid) begin
        dvd_valid <= 1'b1;
        dvd_data  <= s_axis_dividend_tdata;
        dvd_tag   <= s_axis_dividend_tuser;
      end else if (start) begin
        dvd_valid <= 1'b0;
      end
      if (s_axis_divisor_tvalid && !dvs_valid) begin
        dvs_valid <= 1'b1;
        dvs_data  <= s_axis_divisor_tdata;
      end else if (start) begin
        dvs_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      num     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs_mag <= '0;
      neg     <= 1'b0;
      dbz     <= 1'b0;
      tag     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            num     <= NUM_W'(dvd_abs) << FRACTIONAL_WIDTH;
            quo     <= '0;
            rem     <= '0;
            dvs_mag <= dvs_abs;
            neg     <= dvd_data[DW-1] ^ dvs_data[VW-1];
            tag     <= dvd_tag;
            cnt     <= CNT_W'(NUM_W - 1);
            dbz     <= (dvs_data == '0);
            state   <= (dvs_data == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          num <= num << 1;
          rem <= ge ? rem_sub[VW-1:0] : rem_sh[VW-1:0];
          quo <= {quo[NUM_W-2:0], ge};
          if (cnt == '0) state <= FIN;
          else cnt <= cnt - 1'b1;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Show-ahead FIFO; start only fires with a free slot, so push never overflows.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {tag, ovf, dbz, res};
        wr_ptr      <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head               = mem[rd_ptr];
  assign m_axis_dout_tvalid = (occ != '0);
  assign m_axis_dout_tdata  = m_axis_dout_tvalid ? TDATA_W'(signed'(head[OUT_WIDTH-1:0])) : '0;
  assign m_axis_dout_tuser  = m_axis_dout_tvalid ? head[ENTRY_W-1:OUT_WIDTH] : '0;
endmodule

// File: doc/div_rasterizer_iter.md
Name: div_rasterizer_iter

Overview:
- Parametrised, multi-cycle signed fixed-point divider for the rasterizer. Successor to the single-shot combinational divide stub.
- Computes trunc((dividend << FRACTIONAL_WIDTH) / divisor) with a radix-2 non-restoring/restoring iteration, one quotient bit per cycle.
- Carries a per-operation tag, flags divide-by-zero and overflow, and buffers results in an output FIFO so the edge-function setup logic can run ahead of the consumer.

Parameters:
- DIVIDEND_WIDTH, 64: signed dividend width (DW).
- DIVISOR_WIDTH, 64: signed divisor width (VW).
- FRACTIONAL_WIDTH, 16: left shift applied to dividend (F).
- OUT_WIDTH, DW+F+1: signed result width kept; may be smaller than DW+F+1.
- TAG_WIDTH, 4: width of the tag passed from the dividend channel to the result.
- OUT_DEPTH, 4: result FIFO entries, ≥1.
- Derived: NUM_W = DW+F; TDATA_W = 8*ceil(OUT_WIDTH/8).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tready  out  1  dividend latch free.
- s_axis_dividend_tdata  in  DW  signed dividend.
- s_axis_dividend_tuser  in  TAG_WIDTH  operation tag.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tready  out  1  divisor latch free.
- s_axis_divisor_tdata  in  VW  signed divisor.
- m_axis_dout_tvalid  out  1  FIFO head valid.
- m_axis_dout_tready  in  1  consumer ready.
- m_axis_dout_tdata  out  TDATA_W  result, sign-extended from OUT_WIDTH to TDATA_W.
- m_axis_dout_tuser  out  TAG_WIDTH+2  [0] divide-by-zero, [1] overflow, [TAG_WIDTH+1:2] tag.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, aclk. Reset areset is synchronous and active-high.
- Reset values: both input treadys 1; m_axis_dout_tvalid 0; tdata and tuser 0; busy 0. Reset clears both latches, the FSM (to IDLE) and FIFO occupancy.
- Reset mid-operation: the in-flight operation and all FIFO contents are discarded. No output appears after reset deasserts.
- Input latches: one entry per channel, independent.
  - tready = !latch_valid.
  - A channel latches on tvalid & tready.
  - The two channels may complete in different cycles.
- FSM IDLE:
  - Leaves IDLE when both latches are valid and FIFO count < OUT_DEPTH.
  - On that edge, clears both latches and captures operand signs, magnitudes, tag and a zero-divisor check.
  - Divisor == 0: go to FIN with dbz=1, quotient 0. Otherwise go to CALC.
- FSM CALC:
  - Exactly NUM_W edges; each shifts one bit of |dividend|<<F into the remainder and produces one quotient bit (MSB first).
  - After the last edge, go to FIN.
- FSM FIN (one edge):
  - Negates the quotient if the operand signs differ, giving truncation toward zero.
  - Forms the OUT_WIDTH result, pushes {tag, ovf, dbz, result} into the FIFO, returns to IDLE.
- Latency, measured from the edge completing the second operand handshake, with FIFO empty and FSM idle:
  - Nonzero divisor: m_axis_dout_tvalid is seen high after NUM_W+2 edges.
  - Zero divisor: seen high after 2 edges.
- Throughput: one operation per NUM_W+2 cycles. New operands may latch while CALC runs.
- Output FIFO:
  - Show-ahead. Pop on tvalid & tready.
  - Push and pop in the same cycle keep the count unchanged.
  - A full FIFO stalls the FSM in IDLE. Push never overflows.
  - Order of results equals order of operand pairs.
- Width and overflow:
  - Full quotient is DW+F+1 bits signed, so with default OUT_WIDTH no overflow is possible.
  - If the quotient does not fit OUT_WIDTH signed, ovf = 1.
  - Without the optional feature: data = low OUT_WIDTH bits, and ovf is still reported.

Optional Feature:
- Macro: DIV_SATURATE_EN.
- When defined: an out-of-range quotient clamps to +(2^(OUT_WIDTH-1)-1) or -2^(OUT_WIDTH-1), and ovf = 1.
- When not defined: low OUT_WIDTH bits are kept (wrap), and ovf = 1.
- Divide-by-zero output is 0 in both builds.

Test Plan:
All scenarios use DW=VW=8, F=4, OUT_WIDTH=13, TAG_WIDTH=4, OUT_DEPTH=2, so NUM_W=12 and latency is 14.
1. Dividend 7 with tag 3 and divisor 2, same cycle, tready 1 -> tdata 0x0038 (56) with sign extension to 16 bits, tuser {3,0,0}, tvalid 14 edges after the handshake edge.
2. Dividends -7 / 7 and divisors 2 / -2, all four sign combinations -> -56, -56, 56, 56. The result for -1/3 is 0xFFFB (-5, truncated toward zero).
3. Dividend 5 with tag 9 and divisor 0 -> tdata 0, tuser[0]=1, tag 9, tvalid after 2 edges. A following 4/1 returns 64.
4. Dividend -128 and divisor -1 -> 2048 (0x0800), ovf 0. With OUT_WIDTH=10:
   - Without the macro: data 0, ovf 1.
   - With DIV_SATURATE_EN: 511, ovf 1.
5. m_axis_dout_tready held 0 while four pairs with tags 0-3 are offered:
   - Two results fill the FIFO; the third pair is taken into the FSM-idle latches, after which both input treadys stay 0 and busy is 0.
   - Raising tready delivers tags 0, 1, 2, 3 in order, with no loss or duplication.
6. Assert areset for one cycle during CALC and with 1 FIFO entry held -> tvalid 0 the next cycle, both treadys 1, and no stale result afterward. A new 7/2 gives 56 at 14 edges.
